dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-port arbiter that shares the single-ported data memory between the pipeline's M-stage load/store port (port 0) and a bridge/debug master (port 1). Each cycle it grants at most one single-word access, forwarding address, write-enable and write data to the memory and returning the memory's combinational read data to the winner. Port 0 has fixed priority, bounded by a starvation counter that forces a grant to port 1. Port 1 may lock the memory for a bounded burst. It sits between the M stage and the data memory, and drives a stall to the pipeline hazard unit.

## Interface
- STARVE_MAX, 4: consecutive blocked cycles after which a pending port-1 request preempts port 0 (1..7).
- LOCK_MAX, 8: maximum beats in one port-1 locked burst (1..15).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- m0_req  in  1  port 0 access request (M-stage load or store).
- m0_we  in  1  port 0 write (sw) when 1, read when 0.
- m0_addr  in  32  port 0 byte address.
- m0_wdata  in  32  port 0 store data.
- m0_ready  out  1  port 0 granted this cycle; the access completes this cycle.
- m0_rdata  out  32  read data to port 0, valid when m0_ready & ~m0_we.
- m0_stall  out  1  m0_req & ~m0_ready; freezes PC/IF/ID/EX/M registers.
- m1_req, m1_we, m1_addr[31:0], m1_wdata[31:0], m1_ready, m1_rdata[31:0]  same as port 0, for port 1.
- m1_lock  in  1  sampled on a granted port-1 beat; requests that the next beat is also granted to port 1.
- mem_addr  out  32  address to data memory (word index = mem_addr[11:2]).
- mem_we  out  1  memory write strobe.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  combinational memory read data.
- grant_last  out  2  registered: 2'b01 port 0, 2'b10 port 1, 2'b00 none, for the most recent cycle.

## Operation
- State: mode {IDLE, LOCK1}, starve_cnt (3 bits), lock_cnt (4 bits).
- Grant (combinational, per cycle), evaluated in order:
  - reset high: no grant.
  - mode==LOCK1 and m1_req: port 1.
  - m1_req and starve_cnt==STARVE_MAX: port 1.
  - m0_req: port 0.
  - m1_req: port 1.
  - otherwise none.
- Ungranted cycle: mem_we=0; mem_addr/mem_wdata hold port 0 values (don't-care). Granted: mem_* driven from the winner; mN_rdata = mem_rdata for both ports (qualify with ready).
- Writes are never issued without a grant; mem_we = granted port's we.
- starve_cnt: cleared when port 1 is granted or m1_req=0; else incremented when m1_req and port 1 is not granted, saturating at STARVE_MAX.
- Lock:
  - IDLE -> LOCK1 when port 1 is granted with m1_lock=1; lock_cnt <= 1.
  - In LOCK1, each granted beat with m1_lock=1 increments lock_cnt.
  - LOCK1 -> IDLE when any of:
    - the granted beat has m1_lock=0;
    - m1_req=0 (lock dropped; that cycle arbitrates normally);
    - a granted beat is made with lock_cnt==LOCK_MAX.
  - After a LOCK_MAX release, port 1 is masked for exactly one cycle if m0_req is high, so port 0 gets a beat.
- Requesters hold req/we/addr/wdata stable until ready; the arbiter does not register them.
- Addresses pass unmodified; alignment is the requester's responsibility.

## Timing
- Zero-latency grant: ready is asserted in the same cycle as req when the port wins. The memory write occurs on that cycle's rising edge, and read data is valid in that cycle.
- Worst-case port-1 wait with port 0 continuously requesting: STARVE_MAX cycles, then granted on cycle STARVE_MAX+1.
- Reset values: mode=IDLE, starve_cnt=0, lock_cnt=0, grant_last=2'b00. m0_ready=m1_ready=0, mem_we=0, and m0_stall=m0_req while reset is high.
- Reset mid-lock: the lock is abandoned; the next cycle after reset, arbitration is normal with port 0 priority.
- Simultaneous requests to the same address: only the winner accesses memory. A port-0 write followed by a port-1 read in the next cycle sees the new data.

## Test plan
- Port 0 only: m0 sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> m0_ready=1 both cycles, m0_stall=0, m0_rdata=0xDEADBEEF, grant_last=01.
- Contention, STARVE_MAX=4: m0_req and m1_req held high -> port 0 granted cycles 1-4, port 1 granted cycle 5 (m0_stall=1 that cycle), starve_cnt back to 0, port 0 granted cycle 6.
- Idle port 0: m1 read addr 0x20 with m0_req=0 -> m1_ready=1 in the same cycle, m1_rdata = memory word 8.
- Lock burst: m1_lock=1 for 3 beats then 0, with m0_req high -> port 1 granted 4 consecutive cycles, then port 0; m0_stall high for those 4 cycles.
- Lock overrun, LOCK_MAX=8: m1_lock held 1 and m0_req high -> 8 port-1 beats, then one port-0 beat, then port 1 may relock.
- Reset during LOCK1 with m0 write pending -> no mem_we while reset is high, outputs at reset values; the first cycle after reset grants port 0.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// Single-word memory access port shared by the arbiter's two requesters.
// The master side is the requester (M stage or bridge/debug master), the
// slave side is the arbiter.
interface dm_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ready,
        output rdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: port 0 (M-stage load/store) has fixed priority,
// port 1 (bridge/debug) is protected by a starvation counter and may lock
// the memory for a bounded burst. Grants are combinational (zero latency);
// only the arbitration state and grant_last are registered.
module dm_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic        clk,
    input  logic        reset,
    dm_arbiter_if.slave m0,
    dm_arbiter_if.slave m1,
    input  logic        m1_lock,
    output logic        m0_stall,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  grant_last
);

    localparam logic [0:0] MODE_IDLE  = 1'b0;
    localparam logic [0:0] MODE_LOCK1 = 1'b1;

    localparam logic [2:0] STARVE_MAX_C = 3'(STARVE_MAX);
    localparam logic [3:0] LOCK_MAX_C   = 4'(LOCK_MAX);

    logic [0:0] mode_r;
    logic [0:0] mode_s;
    logic [2:0] starve_cnt_r;
    logic [2:0] starve_cnt_s;
    logic [3:0] lock_cnt_r;
    logic [3:0] lock_cnt_s;
    logic       mask_r;
    logic       mask_s;
    logic [1:0] grant_last_r;

    logic       grant0_s;
    logic       grant1_s;
    logic       m1_masked_s;

    // One cycle after a burst hits its beat limit, port 1 yields to a waiting port 0.
    assign m1_masked_s = mask_r & m0.req;

    // Grant decision, highest priority first.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (reset) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if ((mode_r == MODE_LOCK1) && m1.req) begin
            grant1_s = 1'b1;
        end else if (m1.req && (starve_cnt_r == STARVE_MAX_C) && !m1_masked_s) begin
            grant1_s = 1'b1;
        end else if (m0.req) begin
            grant0_s = 1'b1;
        end else if (m1.req && !m1_masked_s) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Memory-side mux: the winner drives the memory; no write without a grant.
    always_comb begin
        mem_addr  = m0.addr;
        mem_wdata = m0.wdata;
        mem_we    = 1'b0;
        if (grant1_s) begin
            mem_addr  = m1.addr;
            mem_wdata = m1.wdata;
            mem_we    = m1.we;
        end else if (grant0_s) begin
            mem_we    = m0.we;
        end else begin
            mem_we    = 1'b0;
        end
    end

    assign m0.ready  = grant0_s;
    assign m1.ready  = grant1_s;
    assign m0.rdata  = mem_rdata;
    assign m1.rdata  = mem_rdata;
    assign m0_stall  = m0.req & ~grant0_s;
    assign grant_last = grant_last_r;

    // Starvation counter: counts consecutive cycles port 1 waits, saturating.
    always_comb begin
        starve_cnt_s = starve_cnt_r;
        if (grant1_s || !m1.req) begin
            starve_cnt_s = 3'd0;
        end else if (starve_cnt_r < STARVE_MAX_C) begin
            starve_cnt_s = starve_cnt_r + 3'd1;
        end else begin
            starve_cnt_s = starve_cnt_r;
        end
    end

    // Lock FSM: lock_cnt counts beats granted in the current burst, the
    // burst ends on the beat that brings it to LOCK_MAX.
    always_comb begin
        mode_s     = mode_r;
        lock_cnt_s = lock_cnt_r;
        mask_s     = 1'b0;
        case (mode_r)
            MODE_IDLE: begin
                if (grant1_s && m1_lock) begin
                    if (LOCK_MAX_C <= 4'd1) begin
                        mode_s     = MODE_IDLE;
                        lock_cnt_s = 4'd0;
                        mask_s     = 1'b1;
                    end else begin
                        mode_s     = MODE_LOCK1;
                        lock_cnt_s = 4'd1;
                    end
                end else begin
                    mode_s     = MODE_IDLE;
                    lock_cnt_s = lock_cnt_r;
                end
            end
            MODE_LOCK1: begin
                if (!m1.req) begin
                    mode_s     = MODE_IDLE;
                    lock_cnt_s = 4'd0;
                end else if (grant1_s) begin
                    if (!m1_lock) begin
                        mode_s     = MODE_IDLE;
                        lock_cnt_s = 4'd0;
                    end else if ((lock_cnt_r + 4'd1) == LOCK_MAX_C) begin
                        mode_s     = MODE_IDLE;
                        lock_cnt_s = 4'd0;
                        mask_s     = 1'b1;
                    end else begin
                        lock_cnt_s = lock_cnt_r + 4'd1;
                    end
                end else begin
                    mode_s     = mode_r;
                    lock_cnt_s = lock_cnt_r;
                end
            end
            default: begin
                mode_s     = MODE_IDLE;
                lock_cnt_s = 4'd0;
            end
        endcase
    end

    // State registers; reset abandons any lock and clears the grant history.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_r       <= MODE_IDLE;
            starve_cnt_r <= 3'd0;
            lock_cnt_r   <= 4'd0;
            mask_r       <= 1'b0;
            grant_last_r <= 2'b00;
        end else begin
            mode_r       <= mode_s;
            starve_cnt_r <= starve_cnt_s;
            lock_cnt_r   <= lock_cnt_s;
            mask_r       <= mask_s;
            grant_last_r <= {grant1_s, grant0_s};
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed testbench for dm_arbiter (STARVE_MAX=4, LOCK_MAX=8) with a
// simple behavioural data memory.
module tb_dm_arbiter;

    logic        clk;
    logic        reset;
    logic        m1_lock;
    logic        m0_stall;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  grant_last;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:1023] = '{default: 32'h0};

    dm_arbiter_if p0 ();
    dm_arbiter_if p1 ();

    dm_arbiter #(.STARVE_MAX(4), .LOCK_MAX(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .m0         (p0),
        .m1         (p1),
        .m1_lock    (m1_lock),
        .m0_stall   (m0_stall),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .grant_last (grant_last)
    );

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs after the falling edge and let combinational outputs settle.
    task automatic drive_cycle(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                               input logic lk);
        @(negedge clk);
        p0.req = r0; p0.we = w0; p0.addr = a0; p0.wdata = d0;
        p1.req = r1; p1.we = w1; p1.addr = a1; p1.wdata = d1;
        m1_lock = lk;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_cycle(1'b1, 1'b1, 32'h10, 32'h1111_1111, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        drive_cycle(1'b1, 1'b1, 32'h10, 32'h1111_1111, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        checks++;
        if (p0.ready !== 1'b0 || p1.ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: m0_ready=%b m1_ready=%b expected 0 0", p0.ready, p1.ready);
        end
        checks++;
        if (mem_we !== 1'b0) begin
            errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we);
        end
        checks++;
        if (m0_stall !== 1'b1) begin
            errors++; $display("FAIL reset_stall: got %b expected 1", m0_stall);
        end
        checks++;
        if (grant_last !== 2'b00) begin
            errors++; $display("FAIL reset_grant_last: got %b expected 00", grant_last);
        end
        reset = 1'b0;
        drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_port0_only();
        drive_cycle(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (p0.ready !== 1'b1 || m0_stall !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h10) begin
            errors++; $display("FAIL p0_write: ready=%b stall=%b we=%b addr=%h expected 1 0 1 00000010",
                               p0.ready, m0_stall, mem_we, mem_addr);
        end
        drive_cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (p0.ready !== 1'b1 || m0_stall !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL p0_read_ctl: ready=%b stall=%b we=%b expected 1 0 0", p0.ready, m0_stall, mem_we);
        end
        checks++;
        if (p0.rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL p0_read_data: got %h expected deadbeef", p0.rdata);
        end
        checks++;
        if (grant_last !== 2'b01) begin
            errors++; $display("FAIL p0_grant_last: got %b expected 01", grant_last);
        end
        drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (grant_last !== 2'b01) begin
            errors++; $display("FAIL p0_grant_last2: got %b expected 01", grant_last);
        end
        drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (grant_last !== 2'b00 || mem_we !== 1'b0) begin
            errors++; $display("FAIL idle_grant_last: grant_last=%b we=%b expected 00 0", grant_last, mem_we);
        end
    endtask

    task automatic test_idle_port0();
        drive_cycle(1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        checks++;
        if (p1.ready !== 1'b1 || p0.ready !== 1'b0 || mem_addr !== 32'h20) begin
            errors++; $display("FAIL p1_idle_grant: m1_ready=%b m0_ready=%b addr=%h expected 1 0 00000020",
                               p1.ready, p0.ready, mem_addr);
        end
        checks++;
        if (p1.rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL p1_idle_rdata: got %h expected 12345678", p1.rdata);
        end
        drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (grant_last !== 2'b10) begin
            errors++; $display("FAIL p1_grant_last: got %b expected 10", grant_last);
        end
    endtask

    task automatic test_contention();
        logic e1;
        for (int c = 1; c <= 6; c++) begin
            drive_cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
            e1 = (c == 5);
            checks++;
            if (p0.ready !== !e1 || p1.ready !== e1) begin
                errors++; $display("FAIL contention_grant c%0d: m0_ready=%b m1_ready=%b expected %b %b",
                                   c, p0.ready, p1.ready, !e1, e1);
            end
            checks++;
            if (m0_stall !== e1) begin
                errors++; $display("FAIL contention_stall c%0d: got %b expected %b", c, m0_stall, e1);
            end
            if (c == 5) begin
                checks++;
                if (p1.rdata !== 32'h1234_5678) begin
                    errors++; $display("FAIL contention_rdata: got %h expected 12345678", p1.rdata);
                end
            end
            if (c == 6) begin
                checks++;
                if (grant_last !== 2'b10) begin
                    errors++; $display("FAIL contention_grant_last: got %b expected 10", grant_last);
                end
            end
        end
        drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_lock_burst();
        logic e1;
        for (int c = 1; c <= 10; c++) begin
            drive_cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h40, 32'hB000_0000 + 32'(c), (c < 8));
            e1 = (c >= 5) && (c <= 8);
            checks++;
            if (p0.ready !== !e1 || p1.ready !== e1 || m0_stall !== e1) begin
                errors++; $display("FAIL lock_burst c%0d: m0_ready=%b m1_ready=%b stall=%b expected %b %b %b",
                                   c, p0.ready, p1.ready, m0_stall, !e1, e1, e1);
            end
            checks++;
            if (mem_we !== e1) begin
                errors++; $display("FAIL lock_burst_we c%0d: got %b expected %b", c, mem_we, e1);
            end
        end
        drive_cycle(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (p0.rdata !== 32'hB000_0008) begin
            errors++; $display("FAIL lock_burst_data: got %h expected b0000008", p0.rdata);
        end
        drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_lock_overrun();
        logic e1;
        for (int c = 1; c <= 18; c++) begin
            drive_cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
            e1 = ((c >= 5) && (c <= 12)) || (c >= 17);
            checks++;
            if (p0.ready !== !e1 || p1.ready !== e1) begin
                errors++; $display("FAIL lock_overrun c%0d: m0_ready=%b m1_ready=%b expected %b %b",
                                   c, p0.ready, p1.ready, !e1, e1);
            end
        end
    endtask

    // Entered directly after test_lock_overrun, so port 1 is mid-lock here.
    task automatic test_reset_mid_lock();
        reset = 1'b1;
        drive_cycle(1'b1, 1'b1, 32'h10, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
        checks++;
        if (mem_we !== 1'b0 || p0.ready !== 1'b0 || p1.ready !== 1'b0 || m0_stall !== 1'b1) begin
            errors++; $display("FAIL rst_lock_outputs: we=%b m0_ready=%b m1_ready=%b stall=%b expected 0 0 0 1",
                               mem_we, p0.ready, p1.ready, m0_stall);
        end
        drive_cycle(1'b1, 1'b1, 32'h10, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
        checks++;
        if (grant_last !== 2'b00) begin
            errors++; $display("FAIL rst_lock_grant_last: got %b expected 00", grant_last);
        end
        checks++;
        if (mem[4] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rst_lock_no_write: mem word 4 = %h expected deadbeef", mem[4]);
        end
        reset = 1'b0;
        drive_cycle(1'b1, 1'b1, 32'h10, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
        checks++;
        if (p0.ready !== 1'b1 || p1.ready !== 1'b0 || mem_we !== 1'b1) begin
            errors++; $display("FAIL post_reset_grant: m0_ready=%b m1_ready=%b we=%b expected 1 0 1",
                               p0.ready, p1.ready, mem_we);
        end
        drive_cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++;
        if (p0.rdata !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL post_reset_data: got %h expected 0badf00d", p0.rdata);
        end
    endtask

    initial begin
        reset = 1'b1;
        m1_lock = 1'b0;
        p0.req = 1'b0; p0.we = 1'b0; p0.addr = 32'h0; p0.wdata = 32'h0;
        p1.req = 1'b0; p1.we = 1'b0; p1.addr = 32'h0; p1.wdata = 32'h0;
        test_reset();
        test_port0_only();
        test_idle_port0();
        test_contention();
        test_lock_burst();
        test_lock_overrun();
        test_reset_mid_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
